// File: rtl/lsu_if.sv
// lsu_if: request, response and data-memory signals of the load/store unit.
interface lsu_if #(
  parameter int XLEN = 32,
  parameter int MLEN = 64,
  parameter int MEM_WIDTH = 15
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [XLEN-1:0]      req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic [4:0]           req_rd;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [XLEN-1:0]      resp_data;
  logic [4:0]           resp_rd;
  logic [3:0]           resp_err;
  logic [XLEN-1:0]      resp_addr;
  logic [2:0]           mem_funct3;
  logic [MEM_WIDTH-1:0] mem_rd_addr;
  logic [MLEN-1:0]      mem_rd_data;
  logic [MEM_WIDTH-1:0] mem_wr_addr;
  logic [MLEN-1:0]      mem_wr_data;
  logic                 mem_wr_en;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_data, resp_rd, resp_err, resp_addr,
           mem_funct3, mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_err, resp_addr,
           mem_funct3, mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: checked single-request load/store initiator driving a byte-lane memory port.
// Optional LSU_PERF_CNT_EN adds load/store/fault event counters.
module load_store_unit #(
  parameter int MEM_SIZE = 4096,
  parameter int BYTES_PER_WORD = 8,
  parameter int MEM_BYTES = MEM_SIZE * BYTES_PER_WORD,
  parameter int MEM_WIDTH = $clog2(MEM_BYTES),
  parameter int MLEN = 64,
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        aresetn,
  lsu_if.slave        bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_faults
`endif
);
  localparam int OFFW = $clog2(BYTES_PER_WORD);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic we_q, accept, illegal, mis;
  logic [3:0] err;
  logic [MLEN-1:0] wr_shift;
  logic unused_hi;
  assign unused_hi = ^bus.mem_rd_data[MLEN-1:XLEN];
  always_comb begin
    illegal = bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11 || (bus.req_we && bus.req_funct3[2]);
    mis = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
          (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
    err = {illegal, bus.req_addr >= XLEN'(MEM_BYTES), bus.req_we && mis, !bus.req_we && mis};
  end
  assign wr_shift = MLEN'(bus.req_wdata) << {bus.req_addr[OFFW-1:0], 3'b000};
  // req_ready is gated by reset so every output reads 0 while aresetn is low
  assign bus.req_ready = aresetn && (state == IDLE || (state == RESP && bus.resp_ready));
  assign accept = bus.req_valid && bus.req_ready;
  assign bus.resp_valid = state == RESP;
  assign bus.mem_wr_en = state == ACCESS && we_q;
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (accept) state_n = |err ? RESP : ACCESS;
    else if (state == ACCESS) state_n = RESP;
    else if (state == RESP && bus.resp_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      we_q <= 1'b0;
      bus.resp_data <= '0;
      bus.resp_rd <= '0;
      bus.resp_err <= '0;
      bus.resp_addr <= '0;
      bus.mem_funct3 <= '0;
      bus.mem_rd_addr <= '0;
      bus.mem_wr_addr <= '0;
      bus.mem_wr_data <= '0;
    end else if (accept) begin
      we_q <= bus.req_we;
      bus.resp_data <= '0;
      bus.resp_rd <= bus.req_rd;
      bus.resp_err <= err;
      bus.resp_addr <= bus.req_addr;
      if (err == 4'd0) begin
        bus.mem_funct3 <= bus.req_funct3;
        bus.mem_rd_addr <= bus.req_addr[MEM_WIDTH-1:0];
        bus.mem_wr_addr <= bus.req_addr[MEM_WIDTH-1:0];
        if (bus.req_we) bus.mem_wr_data <= wr_shift;
      end
    end else if (state == ACCESS && !we_q) bus.resp_data <= bus.mem_rd_data[XLEN-1:0];
`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or negedge aresetn)
    if (!aresetn) begin
      perf_loads <= '0;
      perf_stores <= '0;
      perf_faults <= '0;
    end else begin
      if (state == ACCESS && !we_q) perf_loads <= perf_loads + 32'd1;
      if (state == ACCESS && we_q) perf_stores <= perf_stores + 32'd1;
      if (accept && |err) perf_faults <= perf_faults + 32'd1;
    end
`endif
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory load/store interface. It accepts one load/store request at a time from the execute stage, checks alignment, range and width, and drives the byte-lane memory port: funct3, read/write address, write data and write enable. It places store data on the correct byte lanes, captures the memory's already-extended read data and returns a registered response to writeback over a valid/ready handshake.

Parameters:
MEM_SIZE, 4096, number of memory words
BYTES_PER_WORD, 8, bytes per memory access word
MEM_BYTES, MEM_SIZE*BYTES_PER_WORD, addressable bytes
MEM_WIDTH, $clog2(MEM_BYTES), memory byte-address width
MLEN, 64, memory data width in bits
XLEN, 32, core register width

Ports:
clk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  XLEN  effective byte address
req_wdata  in  XLEN  store data, right-justified
req_rd  in  5  destination register tag
resp_valid  out  1  response valid
resp_ready  in  1  writeback accepts response
resp_data  out  XLEN  load result (0 for stores and faults)
resp_rd  out  5  echoed req_rd
resp_err  out  4  [0] load misaligned, [1] store misaligned, [2] access fault, [3] illegal width
resp_addr  out  XLEN  echoed req_addr (bad address on fault)
mem_funct3  out  3  to memory funct3
mem_rd_addr  out  MEM_WIDTH  memory read address
mem_rd_data  in  MLEN  memory read data, already compacted and extended
mem_wr_addr  out  MEM_WIDTH  memory write address
mem_wr_data  out  MLEN  lane-aligned write data
mem_wr_en  out  1  memory write strobe

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset: state IDLE; every output 0 (req_ready becomes 1 once in IDLE after reset release).
- req_ready = (state==IDLE) || (state==RESP && resp_ready).
- On acceptance, latch we, funct3, addr, wdata and rd, and compute the checks:
  - illegal width: funct3 in {011,110,111}, or a store with funct3[2]=1
  - misaligned: halfword with addr[0]!=0; word with addr[1:0]!=0
  - access fault: addr >= MEM_BYTES
- Any check set: go straight to RESP. resp_err takes the set bits, resp_data=0, no memory access. Otherwise go to ACCESS.
- ACCESS lasts exactly one cycle, then RESP.
  - mem_rd_addr = mem_wr_addr = addr[MEM_WIDTH-1:0]; mem_funct3 = latched funct3.
  - Store: mem_wr_en=1 for this cycle only. mem_wr_data = zero-extended wdata << (8*addr[$clog2(BYTES_PER_WORD)-1:0]), truncated to MLEN.
  - Load: resp_data <= mem_rd_data[XLEN-1:0] at the closing edge.
- mem_wr_en is 0 in every state except ACCESS for a store. Other mem_* outputs hold their last values.
- Latency: accepted at edge N; ACCESS during cycle N..N+1; resp_valid high after edge N+1. Fault responses appear after edge N.
- RESP: resp_valid=1, and resp_* stay stable until resp_valid&&resp_ready.
  - On that edge, a simultaneous req_valid is accepted (back-to-back).
  - Without a new request, the FSM returns to IDLE and resp_valid falls.
- Reset during any state: the FSM returns to IDLE immediately, mem_wr_en drops asynchronously and the in-flight request is discarded without a response.

Optional Feature:
LSU_PERF_CNT_EN:
- Defined: adds outputs perf_loads, perf_stores and perf_faults (32 bits each, reset 0).
  - perf_loads/perf_stores increment on entering RESP from ACCESS for a load/store.
  - perf_faults increments on entering RESP with a nonzero error.
  - Counters wrap modulo 2^32.
- Undefined: these ports and counters do not exist.

Test Plan:
- SW 0xDEADBEEF @0x14 → ACCESS: mem_wr_en=1 for one cycle, mem_wr_data=0xDEADBEEF_00000000. Then LW @0x14 (mem_rd_data[31:0]=0xDEADBEEF) → resp_data=0xDEADBEEF, resp_err=0.
- SB 0x80 @0x23 → mem_wr_data=0x00000000_80000000. LB @0x23 with mem returning 0xFFFFFF80 → resp_data=0xFFFFFF80; LBU returning 0x80 → 0x00000080.
- LH @0x101 → resp_err=0001, resp_addr=0x101, resp_data=0, response one cycle after acceptance. SW @0x102 → resp_err=0010. mem_wr_en never asserts in either case.
- LW @0x8000 (MEM_BYTES) → resp_err=0100. SD (funct3=011) @0x0 → resp_err=1000.
- resp_ready held 0 for 3 cycles in RESP → resp_* stable, req_ready=0. Then resp_ready=1 with req_valid=1 → new request accepted that edge, next response follows with no IDLE gap.
- aresetn pulled low mid-ACCESS of SW @0x40 → mem_wr_en=0 immediately, resp_valid=0, memory @0x40 unchanged, req_ready=1 after reset release.
